// File: rtl/instr_pkg.sv
// Shared opcodes, instruction field positions and execution-unit state encoding.
// Instruction word is [7:5] opcode, [4:0] zero-extended operand.
package instr_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_LDI  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int OPND_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MUL,
    ST_WB,
    ST_HALT
  } state_t;
endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: ACC_W-bit multiplicand times 5-bit multiplier.
// Runs OPND_W cycles after start; product is the combinational sum for the current step.
module shift_add_mul
  import instr_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ACC_W-1:0]     multiplicand,
  input  logic [OPND_W-1:0]    multiplier,
  output logic [2*ACC_W-1:0]   product,
  output logic                 done
);
  logic [2*ACC_W-1:0] mcand;
  logic [2*ACC_W-1:0] psum;
  logic [OPND_W-1:0]  mplier;
  logic [2:0]         cnt;
  logic               active;

  // Product already includes this cycle's partial term so the caller can latch it on the last step.
  assign product = psum + (mplier[0] ? mcand : '0);
  assign done    = active && (cnt == 3'(OPND_W - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      psum   <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      mcand  <= (2*ACC_W)'(multiplicand);
      mplier <= multiplier;
      psum   <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      psum   <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 3'd1;
      if (done) active <= 1'b0;
    end
  end
endmodule

// File: rtl/instr_exec.sv
// Accumulator execution unit: FETCH/EXEC(/MUL x5)/WB per instruction, pc_ena+retire in WB.
// Stops at the next instruction boundary when run drops; HALT holds until reset.
module instr_exec
  import instr_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [7:0]       instr_in,
  output logic             pc_ena,
  output logic [ACC_W-1:0] acc_out,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             retire,
  output logic             halted
);
  state_t             state;
  logic [7:0]         ir;
  logic [ACC_W-1:0]   acc;
  logic [2:0]         opc;
  logic [ACC_W-1:0]   opd;
  logic               mul_start;
  logic               mul_done;
  logic [2*ACC_W-1:0] product;

  assign opc       = ir[OPC_MSB:OPC_LSB];
  assign opd       = ACC_W'(ir[OPND_W-1:0]);
  assign mul_start = (state == ST_EXEC) && (opc == OP_MUL);
  assign acc_out   = acc;

  shift_add_mul #(.ACC_W(ACC_W)) u_mul (
    .clock        (clock),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (acc),
    .multiplier   (ir[OPND_W-1:0]),
    .product      (product),
    .done         (mul_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      ir     <= '0;
      acc    <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      pc_ena <= 1'b0;
      retire <= 1'b0;
      halted <= 1'b0;
    end else begin
      pc_ena <= 1'b0;
      retire <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          ir    <= instr_in;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Most opcodes finish here; MUL and HALT override the WB handoff below.
          state  <= ST_WB;
          pc_ena <= 1'b1;
          retire <= 1'b1;
          case (opc)
            OP_ADD: {carry, acc} <= {1'b0, acc} + {1'b0, opd};
            OP_SUB: begin
              acc   <= acc - opd;
              carry <= (acc < opd);
            end
            OP_MUL: begin
              state  <= ST_MUL;
              pc_ena <= 1'b0;
              retire <= 1'b0;
            end
            OP_AND: begin
              acc   <= acc & opd;
              carry <= 1'b0;
            end
            OP_OR: begin
              acc   <= acc | opd;
              carry <= 1'b0;
            end
            OP_XOR: begin
              acc   <= acc ^ opd;
              carry <= 1'b0;
            end
            OP_LDI: acc <= opd;
            default: begin
              state  <= ST_HALT;
              pc_ena <= 1'b0;
              retire <= 1'b0;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
          endcase
        end
        ST_MUL: begin
          if (mul_done) begin
            acc    <= product[ACC_W-1:0];
            carry  <= |product[2*ACC_W-1:ACC_W];
            state  <= ST_WB;
            pc_ena <= 1'b1;
            retire <= 1'b1;
          end
        end
        ST_WB: begin
          zero <= (acc == '0);
          if (run) begin
            state <= ST_FETCH;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_HALT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_exec.sv
// Scoreboard bench for instr_exec: an instruction-level arithmetic model queues expected
// results per program; a negedge monitor checks each retire, its latency and the zero flag.
module tb_instr_exec;
  localparam int W = 8;
  localparam int M = 256;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         run   = 1'b0;
  logic [7:0]   instr_in;
  logic         pc_ena, zero, carry, busy, retire, halted;
  logic [W-1:0] acc_out;

  logic [7:0] prog [64];
  logic [5:0] pc;

  typedef struct {
    int acc;
    bit carry;
    bit zero;
    int lat;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_ret_cyc = 0;
  int pe_cnt = 0;
  bit zpend = 1'b0;
  bit zexp = 1'b0;

  int         m_acc = 0;
  bit         m_carry = 1'b0;
  bit         m_zero = 1'b0;
  logic [5:0] mpc = '0;

  instr_exec #(.ACC_W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .instr_in (instr_in),
    .pc_ena   (pc_ena),
    .acc_out  (acc_out),
    .zero     (zero),
    .carry    (carry),
    .busy     (busy),
    .retire   (retire),
    .halted   (halted)
  );

  always #5 clock = ~clock;

  // Neighbouring PC/ROM block: PC advances on the edge that ends a pc_ena cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) pc <= '0;
    else if (pc_ena) pc <= pc + 6'd1;
  end
  assign instr_in = prog[pc];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Instruction semantics as plain integer arithmetic modulo 2^W.
  task automatic model_step(input logic [7:0] ins);
    int op, v, r;
    exp_t e;
    op = int'(ins[7:5]);
    v  = int'(ins[4:0]);
    case (op)
      0: begin r = m_acc + v; m_carry = (r >= M); m_acc = r % M; end
      1: begin m_carry = (m_acc < v); m_acc = (m_acc - v + M) % M; end
      2: begin r = m_acc * v; m_carry = (r >= M); m_acc = r % M; end
      3: begin m_acc = m_acc & v; m_carry = 1'b0; end
      4: begin m_acc = m_acc | v; m_carry = 1'b0; end
      5: begin m_acc = m_acc ^ v; m_carry = 1'b0; end
      6: m_acc = v;
      default: ;
    endcase
    m_zero  = (m_acc == 0);
    e.acc   = m_acc;
    e.carry = m_carry;
    e.zero  = m_zero;
    e.lat   = (op == 2) ? 8 : 3;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_carry = 1'b0;
    m_zero  = 1'b0;
    mpc     = '0;
  endtask

  // Monitor: compare every retire against the head of the scoreboard.
  always @(negedge clock) begin
    exp_t it;
    if (reset) begin
      zpend = 1'b0;
    end else begin
      if (zpend) begin
        check("zero", 32'(zero), 32'(zexp));
        zpend = 1'b0;
      end
      if (pc_ena || retire) check("pc_ena_vs_retire", 32'(pc_ena), 32'(retire));
      if (pc_ena) pe_cnt++;
      if (retire) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire: got retire=1 expected none, acc=%0d (t=%0t)", acc_out, $time);
        end else begin
          it = sb.pop_front();
          check("acc", 32'(acc_out), 32'(it.acc));
          check("carry", 32'(carry), 32'(it.carry));
          check("retire_gap", 32'(cyc - last_ret_cyc), 32'(it.lat));
          zpend = 1'b1;
          zexp  = it.zero;
        end
        last_ret_cyc = cyc;
      end
    end
  end

  // Run n instructions from the model PC, dropping run stop_k cycles into the last one.
  task automatic run_phase(input int n, input int stop_k);
    int t;
    @(negedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      model_step(prog[mpc]);
      mpc = mpc + 6'd1;
    end
    last_ret_cyc = cyc;
    run = 1'b1;
    t = 0;
    while (sb.size() > 1 && t < 400) begin
      @(negedge clock); #1;
      t++;
    end
    repeat (stop_k + 1) @(negedge clock);
    #1 run = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clock); #1;
      t++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clock);
    @(negedge clock); #1;
    check("busy_after_stop", 32'(busy), 32'd0);
    check("pc_after_stop", 32'(pc), 32'(mpc));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc"}, 32'(acc_out), 32'd0);
    check({tag, "_flags"}, {27'd0, zero, carry, busy, pc_ena, retire}, 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rom [4];
    logic [2:0] op;
    logic [4:0] v;
    int n, pe0;

    rom[0] = 8'h03; rom[1] = 8'h22; rom[2] = 8'h45; rom[3] = 8'h00;
    for (int i = 0; i < 64; i++) prog[i] = rom[i % 4];

    repeat (3) @(negedge clock);
    #1 check_all_zero("reset");

    // Looping ROM: four passes of ADD 3, SUB 2, MUL 5, NOP.
    pe0 = pe_cnt;
    run_phase(16, 1);
    check("rom_final_acc", 32'(acc_out), 32'd12);
    check("rom_pc_ena_count", 32'(pe_cnt - pe0), 32'd16);

    // LDI 0, SUB 1 (borrow to 0xFF), ADD 1 (carry out to 0).
    prog[mpc] = 8'hC0; prog[mpc + 6'd1] = 8'h21; prog[mpc + 6'd2] = 8'h01;
    run_phase(3, 0);
    check("wrap_acc", 32'(acc_out), 32'd0);
    check("wrap_carry", 32'(carry), 32'd1);
    check("wrap_zero", 32'(zero), 32'd1);

    // Drop run during the second MUL cycle.
    prog[mpc] = 8'hC3; prog[mpc + 6'd1] = 8'h47;
    run_phase(2, 3);
    check("mul_stop_acc", 32'(acc_out), 32'd21);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        op = 3'($urandom_range(0, 6));
        v  = 5'($urandom);
        prog[mpc + 6'(i)] = {op, v};
      end
      op = prog[mpc + 6'(n - 1)][7:5];
      run_phase(n, $urandom_range(0, (op == 3'd2) ? 7 : 2));
    end

    // Reset during the third MUL cycle aborts it.
    prog[mpc] = 8'hC9;
    run_phase(1, 0);
    prog[mpc] = 8'h45;
    @(negedge clock); #1 run = 1'b1;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_all_zero("mid_mul_reset");
    model_reset();
    repeat (2) @(negedge clock);
    run_phase(3, 1);

    // HALT: sticky regardless of run, cleared only by reset.
    @(negedge clock); #1;
    prog[mpc] = 8'hE0;
    pe0 = pe_cnt;
    run = 1'b1;
    repeat (12) @(negedge clock);
    #1;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_pc", 32'(pc), 32'(mpc));
    check("halt_acc", 32'(acc_out), 32'(m_acc));
    run = 1'b0;
    repeat (4) @(negedge clock);
    #1 run = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_no_pc_ena", 32'(pe_cnt - pe0), 32'd0);
    reset = 1'b1;
    #1 check_all_zero("halt_reset");
    model_reset();
    run = 1'b0;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
